reg_bank_scoreboard_ctrl: RTL and testbench

Issue-side controller for the register-bank address register. It accepts decoded operand/destination addresses through a valid/ready handshake and tracks outstanding writes in a per-register busy scoreboard. It stalls on RAW/WAW hazards and, on each accepted instruction, drives the address register's write enables and address inputs. Writeback clears the busy bits.

---
 rtl/reg_bank_scoreboard_ctrl_pkg.sv | 16 +
 rtl/reg_bank_scoreboard_ctrl_busy_table.sv | 50 +++++
 rtl/reg_bank_scoreboard_ctrl.sv | 147 ++++++++++++++
 tb/tb_reg_bank_scoreboard_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_scoreboard_ctrl_pkg.sv
// Shared definitions for the register-bank issue controller:
// FSM state encodings, the hard-wired zero register and default sizes.
package reg_bank_scoreboard_ctrl_pkg;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ADDR_W   = 5;

    localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_STALL = 2'd2
    } state_t;

endpackage

// File: rtl/reg_bank_scoreboard_ctrl_busy_table.sv
// Per-register busy scoreboard with a same-cycle writeback bypass and
// a sticky flag for writebacks that target x0 or a register that is not busy.
module reg_bank_busy_table
    import reg_bank_scoreboard_ctrl_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_set_en,
    input  logic [ADDR_W-1:0]   i_set_addr,
    input  logic                i_wb_valid,
    input  logic [ADDR_W-1:0]   i_wb_addr,
    output logic [NUM_REGS-1:0] o_busy,
    output logic [NUM_REGS-1:0] o_eff_busy,
    output logic                o_wb_clr,
    output logic                o_spurious
);

    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

    logic [NUM_REGS-1:0] r_busy;
    logic                r_spurious;
    logic                w_wb_clr;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic [NUM_REGS-1:0] w_set_mask;

    assign w_wb_clr   = i_wb_valid && (i_wb_addr != ZERO_A) && r_busy[i_wb_addr];
    assign w_clr_mask = w_wb_clr ? (NUM_REGS'(1) << i_wb_addr) : '0;
    assign w_set_mask = (i_set_en && (i_set_addr != ZERO_A)) ? (NUM_REGS'(1) << i_set_addr) : '0;

    // Clear is applied before set so a same-register writeback/issue ends busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= '0;
            r_spurious <= 1'b0;
        end else begin
            r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & ~NUM_REGS'(1);
            if (i_wb_valid && !w_wb_clr)
                r_spurious <= 1'b1;
        end
    end

    assign o_busy     = r_busy;
    assign o_eff_busy = r_busy & ~w_clr_mask;
    assign o_wb_clr   = w_wb_clr;
    assign o_spurious = r_spurious;

endmodule

// File: rtl/reg_bank_scoreboard_ctrl.sv
// Issue-side controller: RAW/WAW hazard stall against the busy scoreboard,
// pending-write limit, registered address-register write pulses and a stall counter.
module reg_bank_scoreboard_ctrl
    import reg_bank_scoreboard_ctrl_pkg::*;
#(
    parameter int NUM_REGS    = DEF_NUM_REGS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int MAX_PENDING = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                               reg_clk,
    input  logic                               reg_rst,
    input  logic                               instr_valid,
    output logic                               instr_ready,
    input  logic [ADDR_W-1:0]                  rs_1_in,
    input  logic [ADDR_W-1:0]                  rs_2_in,
    input  logic [ADDR_W-1:0]                  rd_in,
    input  logic                               uses_rs_1,
    input  logic                               uses_rs_2,
    input  logic                               writes_rd,
    input  logic                               wb_valid,
    input  logic [ADDR_W-1:0]                  wb_rd,
    output logic                               rs_1_wr_en,
    output logic                               rs_2_wr_en,
    output logic                               rd_wr_en,
    output logic [ADDR_W-1:0]                  rs_1_addr,
    output logic [ADDR_W-1:0]                  rs_2_addr,
    output logic [ADDR_W-1:0]                  rd_addr,
    output logic [NUM_REGS-1:0]                busy_vec,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending_cnt,
    output logic [STALL_CNT_W-1:0]             stall_cnt,
    output logic                               spurious_wb,
    output logic [1:0]                         state
);

    localparam int                PC_W     = $clog2(MAX_PENDING + 1);
    localparam logic [PC_W-1:0]   PEND_MAX = PC_W'(MAX_PENDING);
    localparam logic [ADDR_W-1:0] ZERO_A   = ADDR_W'(REG_ZERO);

    // Handshake: an instruction transfers on a rising edge where
    // instr_valid && instr_ready; instr_ready never looks at instr_valid.

    logic [NUM_REGS-1:0]    w_busy;
    logic [NUM_REGS-1:0]    w_eff_busy;
    logic                   w_wb_clr;
    logic                   w_spurious;
    logic                   w_hazard;
    logic                   w_set;
    logic                   w_full;
    logic                   w_ready;
    logic                   w_acc;
    logic [PC_W-1:0]        w_pend_eff;

    logic [PC_W-1:0]        r_pending;
    logic [STALL_CNT_W-1:0] r_stall;
    logic                   r_rs_1_en;
    logic                   r_rs_2_en;
    logic                   r_rd_en;
    logic [ADDR_W-1:0]      r_rs_1_addr;
    logic [ADDR_W-1:0]      r_rs_2_addr;
    logic [ADDR_W-1:0]      r_rd_addr;
    state_t                 r_state;
    state_t                 w_state_next;

    reg_bank_busy_table #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_busy (
        .clk        (reg_clk),
        .rst        (reg_rst),
        .i_set_en   (w_acc && w_set),
        .i_set_addr (rd_in),
        .i_wb_valid (wb_valid),
        .i_wb_addr  (wb_rd),
        .o_busy     (w_busy),
        .o_eff_busy (w_eff_busy),
        .o_wb_clr   (w_wb_clr),
        .o_spurious (w_spurious)
    );

    assign w_hazard = (uses_rs_1 && (rs_1_in != ZERO_A) && w_eff_busy[rs_1_in])
                   || (uses_rs_2 && (rs_2_in != ZERO_A) && w_eff_busy[rs_2_in])
                   || (writes_rd && (rd_in   != ZERO_A) && w_eff_busy[rd_in]);

    assign w_set      = writes_rd && (rd_in != ZERO_A);
    // A retiring writeback frees a pending slot in the same cycle.
    assign w_pend_eff = r_pending - PC_W'(w_wb_clr);
    assign w_full     = (w_pend_eff == PEND_MAX) && w_set;
    assign w_ready    = !w_hazard && !w_full;
    assign w_acc      = instr_valid && w_ready;

    always_ff @(posedge reg_clk or posedge reg_rst) begin
        if (reg_rst) begin
            r_pending   <= '0;
            r_stall     <= '0;
            r_rs_1_en   <= 1'b0;
            r_rs_2_en   <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rs_1_addr <= '0;
            r_rs_2_addr <= '0;
            r_rd_addr   <= '0;
        end else begin
            r_pending <= r_pending + PC_W'(w_acc && w_set) - PC_W'(w_wb_clr);
            if (instr_valid && !w_ready && (r_stall != '1))
                r_stall <= r_stall + 1'b1;
            r_rs_1_en <= w_acc && uses_rs_1;
            r_rs_2_en <= w_acc && uses_rs_2;
            r_rd_en   <= w_acc && writes_rd;
            if (w_acc) begin
                r_rs_1_addr <= rs_1_in;
                r_rs_2_addr <= rs_2_in;
                r_rd_addr   <= rd_in;
            end
        end
    end

    always_ff @(posedge reg_clk or posedge reg_rst) begin
        if (reg_rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = ST_IDLE;
        if (!instr_valid)
            w_state_next = ST_IDLE;
        else if (w_ready)
            w_state_next = ST_ISSUE;
        else
            w_state_next = ST_STALL;
    end

    assign instr_ready = w_ready;
    assign rs_1_wr_en  = r_rs_1_en;
    assign rs_2_wr_en  = r_rs_2_en;
    assign rd_wr_en    = r_rd_en;
    assign rs_1_addr   = r_rs_1_addr;
    assign rs_2_addr   = r_rs_2_addr;
    assign rd_addr     = r_rd_addr;
    assign busy_vec    = w_busy;
    assign pending_cnt = r_pending;
    assign stall_cnt   = r_stall;
    assign spurious_wb = w_spurious;
    assign state       = r_state;

endmodule

// File: tb/tb_reg_bank_scoreboard_ctrl.sv
// Directed and random stimulus for reg_bank_scoreboard_ctrl, checked against
// an array-based scoreboard model that applies the issue/writeback rules directly.
module tb_reg_bank_scoreboard_ctrl;

    localparam int NUM_REGS    = 32;
    localparam int ADDR_W      = 5;
    localparam int MAX_PENDING = 4;
    localparam int STALL_CNT_W = 16;

    logic              reg_clk = 1'b0;
    logic              reg_rst;
    logic              instr_valid;
    logic              instr_ready;
    logic [ADDR_W-1:0] rs_1_in, rs_2_in, rd_in;
    logic              uses_rs_1, uses_rs_2, writes_rd;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_rd;
    logic              rs_1_wr_en, rs_2_wr_en, rd_wr_en;
    logic [ADDR_W-1:0] rs_1_addr, rs_2_addr, rd_addr;
    logic [NUM_REGS-1:0] busy_vec;
    logic [2:0]        pending_cnt;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic              spurious_wb;
    logic [1:0]        state;

    always #5 reg_clk = ~reg_clk;

    reg_bank_scoreboard_ctrl #(
        .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
        .MAX_PENDING(MAX_PENDING), .STALL_CNT_W(STALL_CNT_W)
    ) dut (
        .reg_clk(reg_clk), .reg_rst(reg_rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .rs_1_in(rs_1_in), .rs_2_in(rs_2_in), .rd_in(rd_in),
        .uses_rs_1(uses_rs_1), .uses_rs_2(uses_rs_2), .writes_rd(writes_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .rs_1_wr_en(rs_1_wr_en), .rs_2_wr_en(rs_2_wr_en), .rd_wr_en(rd_wr_en),
        .rs_1_addr(rs_1_addr), .rs_2_addr(rs_2_addr), .rd_addr(rd_addr),
        .busy_vec(busy_vec), .pending_cnt(pending_cnt), .stall_cnt(stall_cnt),
        .spurious_wb(spurious_wb), .state(state)
    );

    // Reference model state
    bit busy_m[NUM_REGS];
    int pend_m, stall_m, state_m;
    bit spur_m, en1_m, en2_m, enw_m;
    int a1_m, a2_m, ad_m;

    int tests, fails;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_REGS-1:0] busy_pack();
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) v[i] = busy_m[i];
        return v;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < NUM_REGS; i++) busy_m[i] = 1'b0;
        pend_m = 0; stall_m = 0; state_m = 0; spur_m = 0;
        en1_m = 0; en2_m = 0; enw_m = 0; a1_m = 0; a2_m = 0; ad_m = 0;
    endtask

    task automatic drv(input bit v, input int r1, input int r2, input int rd,
                       input bit u1, input bit u2, input bit w, input bit wbv, input int wbr);
        instr_valid = v;
        rs_1_in = ADDR_W'(r1); rs_2_in = ADDR_W'(r2); rd_in = ADDR_W'(rd);
        uses_rs_1 = u1; uses_rs_2 = u2; writes_rd = w;
        wb_valid = wbv; wb_rd = ADDR_W'(wbr);
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_busy"},    busy_vec,    busy_pack());
        chk({tag, "_pend"},    pending_cnt, pend_m);
        chk({tag, "_stall"},   stall_cnt,   stall_m);
        chk({tag, "_spur"},    spurious_wb, spur_m);
        chk({tag, "_rs1en"},   rs_1_wr_en,  en1_m);
        chk({tag, "_rs2en"},   rs_2_wr_en,  en2_m);
        chk({tag, "_rden"},    rd_wr_en,    enw_m);
        chk({tag, "_rs1addr"}, rs_1_addr,   a1_m);
        chk({tag, "_rs2addr"}, rs_2_addr,   a2_m);
        chk({tag, "_rdaddr"},  rd_addr,     ad_m);
        chk({tag, "_state"},   state,       state_m);
    endtask

    // One clock: check the combinational ready, cross the edge, update the model, check registers.
    task automatic cycle(input string tag);
        bit v, u1, u2, w, wbv, wbclr, haz, set, full, rdy, acc;
        int r1, r2, rd, wbr;
        bit eff[NUM_REGS];
        #1;
        v = instr_valid; u1 = uses_rs_1; u2 = uses_rs_2; w = writes_rd; wbv = wb_valid;
        r1 = int'(rs_1_in); r2 = int'(rs_2_in); rd = int'(rd_in); wbr = int'(wb_rd);
        wbclr = wbv && (wbr != 0) && busy_m[wbr];
        for (int i = 0; i < NUM_REGS; i++) eff[i] = busy_m[i];
        if (wbclr) eff[wbr] = 1'b0;
        haz = (u1 && r1 != 0 && eff[r1]) || (u2 && r2 != 0 && eff[r2]) || (w && rd != 0 && eff[rd]);
        set = w && (rd != 0);
        full = set && ((pend_m - int'(wbclr)) == MAX_PENDING);
        rdy = !haz && !full;
        acc = v && rdy;
        chk({tag, "_ready"}, instr_ready, rdy);
        @(posedge reg_clk);
        if (wbclr) busy_m[wbr] = 1'b0;
        if (acc && set) busy_m[rd] = 1'b1;
        pend_m = pend_m + int'(acc && set) - int'(wbclr);
        if (wbv && !wbclr) spur_m = 1'b1;
        if (v && !rdy && stall_m < (1 << STALL_CNT_W) - 1) stall_m++;
        en1_m = acc && u1; en2_m = acc && u2; enw_m = acc && w;
        if (acc) begin a1_m = r1; a2_m = r2; ad_m = rd; end
        state_m = !v ? 0 : (acc ? 1 : 2);
        #1;
        check_regs(tag);
    endtask

    initial begin
        tests = 0; fails = 0;
        reg_rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset_model();
        #12;
        check_regs("reset");
        @(posedge reg_clk); #1;
        reg_rst = 1'b0;

        // Asynchronous reset with one outstanding write.
        drv(1, 0, 0, 5, 0, 0, 1, 0, 0); cycle("t1_issue");
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t1_busy5_before", busy_vec[5], 1'b1);
        #2; reg_rst = 1'b1; #1;
        reset_model();
        check_regs("t1_async");
        @(posedge reg_clk); #1;
        reg_rst = 1'b0;

        // RAW stall released by a same-cycle writeback.
        drv(1, 0, 0, 5, 0, 0, 1, 0, 0); cycle("t2_issue");
        drv(1, 5, 0, 0, 1, 0, 0, 0, 0);
        repeat (3) cycle("t2_stall");
        chk("t2_state_stall", state, 2'd2);
        chk("t2_stall_cnt", stall_cnt, 16'd3);
        drv(1, 5, 0, 0, 1, 0, 0, 1, 5); cycle("t2_wb");
        chk("t2_rs1en", rs_1_wr_en, 1'b1);
        chk("t2_rs1addr", rs_1_addr, 5'd5);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle("t2_idle");

        // Writeback and re-issue of the same destination in one cycle.
        drv(1, 0, 0, 7, 0, 0, 1, 0, 0); cycle("t3_issue");
        drv(1, 0, 0, 7, 0, 0, 1, 1, 7); cycle("t3_same");
        chk("t3_busy7", busy_vec[7], 1'b1);
        chk("t3_pend", pending_cnt, 3'd1);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 7); cycle("t3_drain");

        // Pending limit.
        for (int i = 1; i <= 4; i++) begin
            drv(1, 0, 0, i, 0, 0, 1, 0, 0); cycle("t4_fill");
        end
        drv(1, 0, 0, 6, 0, 0, 1, 0, 0);
        repeat (2) cycle("t4_full");
        chk("t4_ready_low", instr_ready, 1'b0);
        drv(1, 0, 0, 0, 0, 0, 1, 0, 0); #1;
        chk("t4_x0_ready", instr_ready, 1'b1);
        cycle("t4_x0");
        drv(1, 0, 0, 6, 0, 0, 1, 1, 1); cycle("t4_wb_frees");
        chk("t4_pend4", pending_cnt, 3'd4);
        for (int i = 2; i <= 6; i++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 1, (i == 5) ? 6 : i);
            if (i != 6) cycle("t4_drain");
        end

        // Spurious writeback.
        drv(0, 0, 0, 0, 0, 0, 0, 1, 9); cycle("t5_spur");
        chk("t5_spur_set", spurious_wb, 1'b1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle("t5_hold");
        chk("t5_spur_hold", spurious_wb, 1'b1);

        // Back-to-back accepts.
        drv(1, 1, 2, 3, 1, 1, 1, 0, 0); cycle("t6_a");
        chk("t6_a_rden", rd_wr_en, 1'b1);
        chk("t6_a_rdaddr", rd_addr, 5'd3);
        drv(1, 4, 0, 0, 1, 0, 0, 0, 0); cycle("t6_b");
        chk("t6_b_rs1en", rs_1_wr_en, 1'b1);
        chk("t6_b_rs1addr", rs_1_addr, 5'd4);
        chk("t6_b_rs2en", rs_2_wr_en, 1'b0);
        chk("t6_b_rden", rd_wr_en, 1'b0);
        chk("t6_b_rdaddr", rd_addr, 5'd0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 3); cycle("t6_drain");

        // Random traffic on a small register window to provoke hazards.
        repeat (400) begin
            drv($urandom_range(0, 3) != 0,
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 7));
            cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
